f1_light_seq: RTL

- Downstream consumer of the programmable tick generator: an F1 start-light sequencer that advances only on the tick pulses it receives.
- On a trigger it lights 8 LEDs one per tick, holds all lit for a pseudo-random number of ticks, then extinguishes them and pulses go.
- It also drives the tick generator's enable, so ticks are counted only while a sequence is running.

---
 rtl/f1_pkg.sv | 18 +
 rtl/lfsr7.sv | 28 ++
 rtl/f1_light_seq.sv | 116 +++++++++++
 3 files changed

// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light sequencer.
package f1_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LIGHT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int LFSR_W = 7;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 7'b1100000;

    // One Fibonacci step of x^7+x^6+1: shift left, feedback enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr7.sv
// Free-running 7-bit maximal-length LFSR used to randomise the hold time.
module lfsr7 import f1_pkg::*; #(
    parameter logic [LFSR_W-1:0] SEED = 7'h01
) (
    input  logic       clk,
    input  logic       rst,
    output logic [6:0] q
);

    logic [LFSR_W-1:0] q_r;

    // An all-zero state is a lock-up point of the sequence.
    if (SEED == 7'h00) begin : g_bad_seed
        $error("lfsr7: SEED must be nonzero");
    end

    // Shift every clock; only reset reloads the seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= SEED;
        end else begin
            q_r <= lfsr_next(q_r);
        end
    end

    assign q = q_r;

endmodule

// File: rtl/f1_light_seq.sv
// F1 start-light sequencer: lights one LED per tick, holds for a random
// number of ticks, then blanks the lights and pulses go.
module f1_light_seq import f1_pkg::*; #(
    parameter int                WIDTH     = 8,
    parameter int                HOLD_BITS = 3,
    parameter int                MIN_HOLD  = 2,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 7'h01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             trigger,
    input  logic             tick,
    output logic             tick_en,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             go
);

    localparam int HC_W = HOLD_BITS + 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(1);

    if (MIN_HOLD < 1 || (MIN_HOLD + (2 ** HOLD_BITS) - 1) > ((2 ** HC_W) - 1)) begin : g_bad_hold
        $error("f1_light_seq: MIN_HOLD out of range for hold counter");
    end
    if (HOLD_BITS < 1 || HOLD_BITS > LFSR_W || WIDTH < 2) begin : g_bad_size
        $error("f1_light_seq: illegal WIDTH/HOLD_BITS");
    end

    state_t            state_r;
    logic [WIDTH-1:0]  data_r;
    logic              busy_r;
    logic              go_r;
    logic              trig_q_r;
    logic [HC_W-1:0]   hold_cnt_r;
    logic [LFSR_W-1:0] lfsr_q_s;
    logic [HC_W-1:0]   hold_load_s;
    logic              trig_rise_s;
    logic              unused_lfsr_s;

    lfsr7 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q_s)
    );

    assign trig_rise_s   = trigger & ~trig_q_r;
    assign hold_load_s   = HC_W'(MIN_HOLD) + {1'b0, lfsr_q_s[HOLD_BITS-1:0]};
    assign unused_lfsr_s = ^lfsr_q_s;

    // Edge detector register; runs regardless of en so a level held while frozen is not a new edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_q_r <= 1'b0;
        end else begin
            trig_q_r <= trigger;
        end
    end

    // Sequencer FSM, light pattern and hold counter; all frozen while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            data_r     <= '0;
            busy_r     <= 1'b0;
            go_r       <= 1'b0;
            hold_cnt_r <= '0;
        end else begin
            go_r <= 1'b0;
            if (en) begin
                case (state_r)
                    IDLE: begin
                        data_r <= '0;
                        if (trig_rise_s) begin
                            state_r <= LIGHT;
                            busy_r  <= 1'b1;
                        end
                    end
                    LIGHT: begin
                        if (tick) begin
                            data_r <= {data_r[WIDTH-2:0], 1'b1};
                            // Lower bits already lit: this tick completes the row.
                            if (&data_r[WIDTH-2:0]) begin
                                state_r    <= HOLD;
                                hold_cnt_r <= hold_load_s;
                            end
                        end
                    end
                    HOLD: begin
                        if (tick) begin
                            if (hold_cnt_r == HOLD_LAST) begin
                                data_r  <= '0;
                                go_r    <= 1'b1;
                                busy_r  <= 1'b0;
                                state_r <= IDLE;
                            end else begin
                                hold_cnt_r <= hold_cnt_r - HC_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        data_r  <= '0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out = data_r;
    assign busy     = busy_r;
    assign go       = go_r;
    assign tick_en  = busy_r & en;

endmodule
